dsp_mac_seq: RTL and testbench

DSP_MAC_SEQ -- requirements
Module: dsp_mac_seq

---
 rtl/dsp_pkg.sv | 42 ++++
 rtl/dsp_sat_acc.sv | 43 ++++
 rtl/dsp_mac_seq.sv | 148 ++++++++++++++
 tb/tb_dsp_mac_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// dsp_pkg: FSM encoding, register map and saturating add shared by dsp_mac_seq.
package dsp_pkg;

    typedef enum logic [1:0] { S_IDLE, S_RUN, S_DRAIN, S_DONE } state_e;

    localparam logic [3:0] ADDR_BASE   = 4'd0;
    localparam logic [3:0] ADDR_LEN    = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;
    localparam logic [3:0] ADDR_ACC0   = 4'd8;

    // Intermediate sum width: holds a 32-bit accumulator plus any product without wrapping.
    localparam int WIDE_W = 40;

    typedef struct packed {
        logic signed [WIDE_W-1:0] sum;
        logic                     sat;
    } sat_res_t;

    // Signed add of two widened operands, clamped into a w-bit signed range.
    function automatic sat_res_t sat_add(input logic signed [WIDE_W-1:0] a,
                                         input logic signed [WIDE_W-1:0] b,
                                         input int                       w);
        logic signed [WIDE_W-1:0] mx;
        logic signed [WIDE_W-1:0] mn;
        logic signed [WIDE_W-1:0] s;
        sat_res_t                 r;
        mx    = (WIDE_W'(1) <<< (w - 1)) - WIDE_W'(1);
        mn    = -mx - WIDE_W'(1);
        s     = a + b;
        r.sum = s;
        r.sat = 1'b0;
        if (s > mx) begin
            r.sum = mx;
            r.sat = 1'b1;
        end else if (s < mn) begin
            r.sum = mn;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_sat_acc.sv
// dsp_sat_acc: one channel accumulator; clears on run start, saturating add of a product.
module dsp_sat_acc
    import dsp_pkg::*;
#(
    parameter int BUS_WIDTH = 24,
    parameter int PROD_W    = 22
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        add_i,
    input  logic signed [PROD_W-1:0]    prod_i,
    output logic signed [BUS_WIDTH-1:0] acc_o,
    output logic                        sat_o
);

    logic signed [BUS_WIDTH-1:0] acc_q;
    logic signed [BUS_WIDTH-1:0] acc_d;
    sat_res_t                    res;

    // Next value: clear wins over add; add is widened then clamped back to the bus range.
    always_comb begin
        res   = sat_add({{(WIDE_W-BUS_WIDTH){acc_q[BUS_WIDTH-1]}}, acc_q},
                        {{(WIDE_W-PROD_W){prod_i[PROD_W-1]}}, prod_i}, BUS_WIDTH);
        acc_d = acc_q;
        sat_o = 1'b0;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = BUS_WIDTH'(res.sum);
            sat_o = res.sat;
        end
    end

    // Accumulator register; clr/add already carry the clock enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: register-programmed sequencer that streams LEN samples from memory,
// multiplies each by a signed coefficient and accumulates round-robin into CHANNELS
// saturating accumulators.
module dsp_mac_seq
    import dsp_pkg::*;
#(
    parameter logic RST_VAL   = 1'b0,
    parameter int   BUS_WIDTH = 24,
    parameter int   CHANNELS  = 4,
    parameter int   MEM_AW    = 6,
    parameter int   SAMPLE_W  = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [7:0]           param,
    input  logic [3:0]           addr,
    input  logic [BUS_WIDTH-1:0] din,
    input  logic                 we,
    output logic [BUS_WIDTH-1:0] dout,
    output logic [MEM_AW-1:0]    memaddr,
    output logic                 mem_re,
    input  logic [SAMPLE_W-1:0]  memdout,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int IW     = MEM_AW + 1;
    localparam int PROD_W = SAMPLE_W + 8;
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_e                            state_q, state_d;
    logic [MEM_AW-1:0]                 base_q, run_base_q;
    logic [IW-1:0]                     len_q, run_len_q, idx_q;
    logic signed [7:0]                 param_q;
    logic                              pend_vld_q;
    logic [CW-1:0]                     pend_ch_q;
    logic                              ovf_q;
    logic [BUS_WIDTH-1:0]              dout_q, rd_data;
    logic                              go;
    logic signed [PROD_W-1:0]          prod;
    logic [CHANNELS-1:0]               sat;
    logic [CHANNELS-1:0][BUS_WIDTH-1:0] acc;

    assign go   = (state_q == S_IDLE) && en && start;
    assign prod = $signed(memdout) * param_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state; everything freezes while en is low.
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                S_IDLE:  if (start) state_d = (len_q == '0) ? S_DONE : S_RUN;
                S_RUN:   if (idx_q + IW'(1) == run_len_q) state_d = S_DRAIN;
                S_DRAIN: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state; a read is only issued on an enabled RUN edge.
    always_comb begin
        busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
        done    = (state_q == S_DONE);
        mem_re  = (state_q == S_RUN) && en;
        memaddr = (state_q == S_RUN) ? run_base_q + idx_q[MEM_AW-1:0] : '0;
    end

    // Registers, run snapshot, sample index and the one-deep read-pending tag.
    // The snapshot uses the pre-edge BASE/LEN, so a same-edge write does not leak into the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            len_q      <= '0;
            run_base_q <= '0;
            run_len_q  <= '0;
            param_q    <= '0;
            idx_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_ch_q  <= '0;
            ovf_q      <= 1'b0;
        end else if (en) begin
            if (state_q == S_IDLE && we) begin
                if (addr == ADDR_BASE) base_q <= MEM_AW'(din);
                if (addr == ADDR_LEN)  len_q  <= IW'(din);
            end
            if (go) begin
                run_base_q <= base_q;
                run_len_q  <= len_q;
                param_q    <= param;
                idx_q      <= '0;
            end else if (state_q == S_RUN) begin
                idx_q <= idx_q + IW'(1);
            end
            pend_vld_q <= (state_q == S_RUN);
            pend_ch_q  <= CW'(idx_q % CHANNELS);
            ovf_q      <= go ? 1'b0 : (ovf_q | (|sat));
        end
    end

    // Channel accumulators: the sample read on the previous enabled edge lands in its channel.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        dsp_sat_acc #(
            .BUS_WIDTH (BUS_WIDTH),
            .PROD_W    (PROD_W)
        ) u_acc (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (go),
            .add_i  (en && pend_vld_q && (pend_ch_q == CW'(c))),
            .prod_i (prod),
            .acc_o  (acc[c]),
            .sat_o  (sat[c])
        );
    end

    // Readback mux; unmapped addresses return zero.
    always_comb begin
        rd_data = '0;
        if (addr == ADDR_BASE)        rd_data = BUS_WIDTH'(base_q);
        else if (addr == ADDR_LEN)    rd_data = BUS_WIDTH'(len_q);
        else if (addr == ADDR_STATUS) rd_data = BUS_WIDTH'({ovf_q, done, busy});
        else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (addr == ADDR_ACC0 + 4'(c)) rd_data = acc[c];
            end
        end
    end

    // Registered readback, updated on enabled non-write edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            dout_q <= {BUS_WIDTH{RST_VAL}};
        else if (en && !we) dout_q <= rd_data;
    end

    assign dout = dout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: scoreboard bench; each run pushes model results, then pops them as the DUT finishes.
module tb_dsp_mac_seq;

    localparam int BW = 16;
    localparam int CH = 4;
    localparam int AW = 6;
    localparam int SW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          start = 1'b0;
    logic          we = 1'b0;
    logic [7:0]    param = '0;
    logic [3:0]    addr = '0;
    logic [BW-1:0] din = '0;
    logic [BW-1:0] dout;
    logic [AW-1:0] memaddr;
    logic          mem_re;
    logic [SW-1:0] memdout = '0;
    logic          busy, done, ovf;

    int mem [64];
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        string              tag;
        logic signed [63:0] val;
    } exp_t;
    exp_t sb[$];

    dsp_mac_seq #(
        .RST_VAL   (1'b1),
        .BUS_WIDTH (BW),
        .CHANNELS  (CH),
        .MEM_AW    (AW),
        .SAMPLE_W  (SW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (start),
        .param   (param),
        .addr    (addr),
        .din     (din),
        .we      (we),
        .dout    (dout),
        .memaddr (memaddr),
        .mem_re  (mem_re),
        .memdout (memdout),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Synchronous sample memory; output holds while mem_re is low.
    always @(posedge clk) if (mem_re) memdout <= SW'(mem[memaddr]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic signed [63:0] val);
        exp_t x;
        x.tag = tag;
        x.val = val;
        sb.push_back(x);
    endtask

    task automatic sb_pop(input logic signed [63:0] got);
        exp_t x;
        if (sb.size() == 0) begin
            chk("sb_underflow", sb.size(), 1);
        end else begin
            x = sb.pop_front();
            chk(x.tag, got, x.val);
        end
    endtask

    task automatic wr(input logic [3:0] a, input int d);
        addr = a;
        din  = BW'(d);
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [BW-1:0] v);
        addr = a;
        we   = 1'b0;
        tick();
        v = dout;
    endtask

    // gaps: en low 3 cycles at idx=2 and idx=5; wmid: write BASE and pulse start mid-run;
    // wstart: write LEN=2 on the start edge itself.
    task automatic do_run(input int base, input int len, input int prm,
                          input bit gaps, input bit wmid, input bit wstart);
        longint        m [CH];
        bit            o;
        int            e, cyc, hold, lat;
        int            obs[$];
        logic [BW-1:0] v;
        o = 1'b0;
        for (int c = 0; c < CH; c++) m[c] = 0;
        for (int i = 0; i < len; i++) begin
            m[i % CH] += longint'(mem[(base + i) % 64]) * prm;
            if (m[i % CH] > 32767) begin
                m[i % CH] = 32767;
                o = 1'b1;
            end else if (m[i % CH] < -32768) begin
                m[i % CH] = -32768;
                o = 1'b1;
            end
        end
        lat = (len == 0) ? 1 : len + 2;
        sb_push("latency", lat);
        sb_push("cycles", lat + (gaps ? 6 : 0));
        sb_push("mem_re_cnt", len);
        for (int i = 0; i < len; i++) sb_push("memaddr", (base + i) % 64);
        sb_push("status", o ? 6 : 2);
        sb_push("ovf", o);
        for (int c = 0; c < CH; c++) sb_push("acc", m[c]);
        sb_push("base_rb", base);
        sb_push("len_rb", wstart ? 2 : len);

        wr(4'd0, base);
        wr(4'd1, len);
        param = 8'(prm);
        start = 1'b1;
        if (wstart) begin
            we   = 1'b1;
            addr = 4'd1;
            din  = 16'd2;
        end
        #1;
        if (mem_re) obs.push_back(int'(memaddr));
        tick();
        start = 1'b0;
        we    = 1'b0;
        e = 1; cyc = 1; hold = 0;
        while (!done && cyc < 300) begin
            en = (hold == 0);
            if (wmid && e == 2) begin
                we = 1'b1; addr = 4'd0; din = 16'd55; start = 1'b1;
            end else begin
                we = 1'b0; start = 1'b0;
            end
            #1;
            if (mem_re) obs.push_back(int'(memaddr));
            tick();
            cyc++;
            if (en) begin
                e++;
                if (gaps && (e == 3 || e == 6)) hold = 3;
            end else begin
                hold--;
            end
        end
        en = 1'b1; we = 1'b0; start = 1'b0;
        chk("done_seen", done, 1);
        sb_pop(e);
        sb_pop(cyc);
        sb_pop(obs.size());
        for (int i = 0; i < len; i++) sb_pop(i < obs.size() ? obs[i] : -1);
        rd(4'd2, v);
        sb_pop(v);
        sb_pop(ovf);
        for (int c = 0; c < CH; c++) begin
            rd(4'(8 + c), v);
            sb_pop($signed(v));
        end
        rd(4'd0, v);
        sb_pop(v);
        rd(4'd1, v);
        sb_pop(v);
    endtask

    initial begin
        logic [BW-1:0] v;
        for (int i = 0; i < 64; i++) mem[i] = i;

        tick();
        tick();
        chk("rst_dout", dout, 16'hFFFF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_memaddr", memaddr, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();
        rd(4'd2, v);  chk("idle_status", v, 0);
        rd(4'd8, v);  chk("acc0_post_rst", v, 0);
        rd(4'hC, v);  chk("unmapped_c", v, 0);
        rd(4'd5, v);  chk("unmapped_5", v, 0);

        do_run(4, 8, 3, 0, 0, 0);
        do_run(62, 4, -5, 0, 0, 0);
        do_run(4, 8, 3, 1, 0, 0);
        do_run(10, 8, -7, 0, 1, 0);
        do_run(4, 8, 3, 0, 0, 1);
        do_run(0, 0, 9, 0, 0, 0);

        for (int i = 0; i < 64; i++) mem[i] = 8191;
        do_run(0, 16, 127, 0, 0, 0);
        do_run(0, 16, -128, 0, 0, 0);
        for (int i = 0; i < 64; i++) mem[i] = i;
        do_run(4, 8, 3, 0, 0, 0);

        // Reset in the middle of a run, with idx=3.
        wr(4'd0, 4);
        wr(4'd1, 8);
        param = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_dout", dout, 16'hFFFF);
        chk("mid_rst_mem_re", mem_re, 0);
        chk("mid_rst_memaddr", memaddr, 0);
        tick();
        rst = 1'b0;
        tick();
        for (int c = 0; c < CH; c++) begin
            rd(4'(8 + c), v);
            chk("acc_after_rst", v, 0);
        end
        rd(4'd0, v); chk("base_after_rst", v, 0);
        rd(4'd1, v); chk("len_after_rst", v, 0);
        rd(4'd2, v); chk("status_after_rst", v, 0);
        do_run(4, 8, 3, 0, 0, 0);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
